// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, bit indices and receiver state encoding
package uart_pkg;
    localparam int UART_FRAME_BITS = 8;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVR       = 2;
    localparam int ST_FERR      = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_RX_EN   = 0;
    localparam int CTRL_IE_DATA = 1;
    localparam int CTRL_IE_ERR  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;
endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver: 2-FF synchroniser, bit-timing FSM and shift register
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       en_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic            r_sync1;
    logic            r_rxs;
    logic            r_rxs_d;
    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_byte_valid;
    logic            r_frame_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_rxs   <= r_sync1;
        end
    end

    // Disabling the receiver behaves like a reset of the frame state.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rxs_d      <= 1'b1;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rxs_d      <= r_rxs;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt     <= '0;
                    r_bit_cnt <= '0;
                    if (r_rxs_d && !r_rxs) r_state <= START;
                end
                START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_state <= r_rxs ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rxs, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'(UART_FRAME_BITS - 1)) r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt <= '0;
                        if (r_rxs) begin
                            r_byte_valid <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (r_rxs) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign byte_valid_o = r_byte_valid;
    assign byte_o       = r_shift;
    assign frame_err_o  = r_frame_err;
endmodule

// File: rtl/wb_uart_rx.sv
// rtl/wb_uart_rx.sv - Wishbone UART receiver with FIFO; UART_RX_IRQ_EN adds CTRL and rx_irq_o
module wb_uart_rx
    import uart_pkg::*;
#(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int CLKS_PER_BIT  = 434,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    input  logic                     uart_rx_i
`ifdef UART_RX_IRQ_EN
    ,
    output logic                     rx_irq_o
`endif
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    logic [7:0]               r_mem [FIFO_DEPTH];
    logic [PW-1:0]            r_wr_ptr, r_rd_ptr;
    logic [CNTW-1:0]          r_count;
    logic                     r_ovr, r_ferr, r_ack;
    logic [WB_DATA_WIDTH-1:0] r_data;

    logic                     w_byte_valid, w_frame_err, w_rx_en;
    logic [7:0]               w_byte;
    logic [1:0]               w_off;
    logic                     w_req, w_empty, w_full, w_pop, w_push, w_ovr_set, w_w1c;
    logic [WB_DATA_WIDTH-1:0] w_status, w_rdata;
    logic                     w_unused;

    assign w_off     = wb_addr_i[3:2];
    assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNTW'(FIFO_DEPTH));
    assign w_pop     = w_req & ~wb_we_i & (w_off == REG_DATA) & ~w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push    = w_byte_valid & (~w_full | w_pop);
    assign w_ovr_set = w_byte_valid & w_full & ~w_pop;
    assign w_w1c     = w_req & wb_we_i & (w_off == REG_STATUS) & wb_sel_i[0];
    assign w_unused  = ^{wb_addr_i, wb_data_i, wb_sel_i};

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (uart_rx_i),
        .en_i         (w_rx_en),
        .byte_valid_o (w_byte_valid),
        .byte_o       (w_byte),
        .frame_err_o  (w_frame_err)
    );

`ifdef UART_RX_IRQ_EN
    logic [2:0] r_ctrl;
    logic       r_irq;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_req && wb_we_i && (w_off == REG_CTRL) && wb_sel_i[0]) r_ctrl <= wb_data_i[2:0];
            r_irq <= (r_ctrl[CTRL_IE_DATA] & ~w_empty) | (r_ctrl[CTRL_IE_ERR] & (r_ovr | r_ferr));
        end
    end

    assign w_rx_en  = r_ctrl[CTRL_RX_EN];
    assign rx_irq_o = r_irq;
`else
    assign w_rx_en = 1'b1;
`endif

    always_comb begin
        w_status                          = '0;
        w_status[ST_NOT_EMPTY]            = ~w_empty;
        w_status[ST_FULL]                 = w_full;
        w_status[ST_OVR]                  = r_ovr;
        w_status[ST_FERR]                 = r_ferr;
        w_status[ST_COUNT_LSB +: CNTW]    = r_count;
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_DATA:   if (!w_empty) w_rdata[8:0] = {1'b1, r_mem[r_rd_ptr]};
            REG_STATUS: w_rdata = w_status;
`ifdef UART_RX_IRQ_EN
            REG_CTRL:   w_rdata[2:0] = r_ctrl;
`else
            REG_CTRL:   w_rdata = '0;
`endif
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= w_byte;
    end

    // Hardware set has priority over a same-cycle W1C.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovr    <= 1'b0;
            r_ferr   <= 1'b0;
            r_ack    <= 1'b0;
            r_data   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovr_set)                          r_ovr <= 1'b1;
            else if (w_w1c && wb_data_i[ST_OVR])    r_ovr <= 1'b0;
            if (w_frame_err)                        r_ferr <= 1'b1;
            else if (w_w1c && wb_data_i[ST_FERR])   r_ferr <= 1'b0;
            r_ack  <= w_req;
            r_data <= w_req ? w_rdata : '0;
        end
    end

    assign wb_ack_o  = r_ack;
    assign wb_data_o = r_data;
endmodule

// File: tb/tb_wb_uart_rx.sv
// tb/tb_wb_uart_rx.sv - directed bench for wb_uart_rx at 16 clocks per bit, 8-entry FIFO
module tb_wb_uart_rx;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_ack;
    logic [31:0] wb_rdata;
    logic        uart_rx = 1'b1;
`ifdef UART_RX_IRQ_EN
    logic        rx_irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd;

    wb_uart_rx #(
        .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wb_addr_i (wb_addr),
        .wb_data_i (wb_wdata),
        .wb_sel_i  (wb_sel),
        .wb_we_i   (wb_we),
        .wb_stb_i  (wb_stb),
        .wb_cyc_i  (wb_cyc),
        .wb_ack_o  (wb_ack),
        .wb_data_o (wb_rdata),
        .uart_rx_i (uart_rx)
`ifdef UART_RX_IRQ_EN
        ,
        .rx_irq_o  (rx_irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_access(input logic [1:0] off, input logic we, input logic [31:0] wd,
                             input logic [3:0] sel, output logic [31:0] d);
        bit ok = 0;
        d        = '0;
        wb_addr  = {28'd0, off, 2'b00};
        wb_we    = we;
        wb_wdata = wd;
        wb_sel   = sel;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (wb_ack) begin
                d  = wb_rdata;
                ok = 1;
                break;
            end
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        if (!ok) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wb_read(input logic [1:0] off, output logic [31:0] d);
        wb_access(off, 1'b0, 32'd0, 4'h0, d);
    endtask

    task automatic wb_write(input logic [1:0] off, input logic [31:0] wd, input logic [3:0] sel);
        logic [31:0] unused_d;
        wb_access(off, 1'b1, wd, sel, unused_d);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cycles(CPB);
        end
        uart_rx = stop_bit;
        cycles(CPB);
        uart_rx = 1'b1;
        cycles(6);
    endtask

    initial begin
        cycles(3);
        rst = 1'b0;
        cycles(2);
        check("reset_ack", {31'd0, wb_ack}, 32'd0);
        check("reset_data_o", wb_rdata, 32'd0);
`ifdef UART_RX_IRQ_EN
        check("reset_irq", {31'd0, rx_irq}, 32'd0);
`endif
        wb_read(2'd1, rd);  check("reset_status", rd, 32'h000);
        wb_read(2'd0, rd);  check("empty_data_read", rd, 32'h000);
        wb_read(2'd2, rd);  check("ctrl_reset", rd, 32'h000);
        wb_read(2'd3, rd);  check("offset3_read", rd, 32'h000);
`ifdef UART_RX_IRQ_EN
        wb_write(2'd2, 32'h1, 4'h1);
`endif

        // single byte
        send_byte(8'hA5, 1'b1);
        wb_read(2'd1, rd);  check("a5_status_before", rd, 32'h101);
        wb_read(2'd0, rd);  check("a5_data", rd, 32'h1A5);
        wb_read(2'd1, rd);  check("a5_status_after", rd, 32'h000);

        // overflow: nine bytes into eight slots
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
        wb_read(2'd1, rd);  check("full_status", rd, 32'h807);
        for (int i = 1; i <= 8; i++) begin
            wb_read(2'd0, rd);
            check($sformatf("fifo_read_%0d", i), rd, 32'h100 + 32'(i));
        end
        wb_read(2'd0, rd);  check("fifo_read_9_empty", rd, 32'h000);
        wb_read(2'd1, rd);  check("ovr_only_status", rd, 32'h004);
        wb_write(2'd1, 32'h4, 4'h0);
        wb_read(2'd1, rd);  check("w1c_without_sel0", rd, 32'h004);
        wb_write(2'd1, 32'h4, 4'h1);
        wb_read(2'd1, rd);  check("w1c_ovr_cleared", rd, 32'h000);

        // framing error, then a break held a full frame plus three bit times
        send_byte(8'h55, 1'b0);
        wb_read(2'd1, rd);  check("ferr_status", rd, 32'h008);
        wb_write(2'd1, 32'h8, 4'h1);
        wb_read(2'd1, rd);  check("ferr_cleared", rd, 32'h000);
        uart_rx = 1'b0;
        cycles(13 * CPB);
        uart_rx = 1'b1;
        cycles(2 * CPB);
        wb_read(2'd1, rd);  check("break_ferr", rd, 32'h008);
        wb_write(2'd1, 32'h8, 4'h1);
        cycles(4 * CPB);
        wb_read(2'd1, rd);  check("break_single_ferr", rd, 32'h000);
        send_byte(8'h3C, 1'b1);
        wb_read(2'd0, rd);  check("after_break_data", rd, 32'h13C);

        // short glitch must be rejected
        uart_rx = 1'b0;
        cycles(4);
        uart_rx = 1'b1;
        cycles(3 * CPB);
        wb_read(2'd1, rd);  check("glitch_status", rd, 32'h000);
        send_byte(8'h5A, 1'b1);
        wb_read(2'd0, rd);  check("after_glitch_data", rd, 32'h15A);

        // reset during the 4th data bit of a frame, with a byte already queued
        send_byte(8'h42, 1'b1);
        wb_read(2'd1, rd);  check("pre_reset_status", rd, 32'h101);
        uart_rx = 1'b0;
        cycles(CPB);
        uart_rx = 1'b1;
        cycles(3 * CPB + CPB / 2);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        #1;
        check("midframe_reset_ack", {31'd0, wb_ack}, 32'd0);
        check("midframe_reset_data_o", wb_rdata, 32'd0);
`ifdef UART_RX_IRQ_EN
        check("midframe_reset_irq", {31'd0, rx_irq}, 32'd0);
        wb_write(2'd2, 32'h1, 4'h1);
`endif
        cycles(12 * CPB);
        wb_read(2'd1, rd);  check("post_reset_status", rd, 32'h000);
        send_byte(8'h7E, 1'b1);
        wb_read(2'd0, rd);  check("post_reset_data", rd, 32'h17E);

`ifdef UART_RX_IRQ_EN
        wb_write(2'd2, 32'h3, 4'h1);
        send_byte(8'h11, 1'b1);
        check("irq_rises", {31'd0, rx_irq}, 32'd1);
        wb_read(2'd0, rd);  check("irq_data", rd, 32'h111);
        check("irq_held_on_ack", {31'd0, rx_irq}, 32'd1);
        cycles(1);
        check("irq_drops", {31'd0, rx_irq}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
